// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU type definitions used by the ALU, its interface and the ALU
// arbiter:
//   aluop_t     - 4-bit ALU operation encoding
//   word_t      - datapath word
//   arb_state_t - state encoding of the shared-ALU arbiter
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int CPU_WORD_W = 32;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu_if.sv
// -----------------------------------------------------------------------------
// alu_if
// Connection to a single combinational ALU.
//   master : drives ALUOP, port_a, port_b; reads port_out and the flags
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
);

  aluop_t            ALUOP;
  logic [WORD_W-1:0] port_a;
  logic [WORD_W-1:0] port_b;
  logic [WORD_W-1:0] port_out;
  logic              negative;
  logic              overflow;
  logic              zero;

  modport master (
    output ALUOP, port_a, port_b,
    input  port_out, negative, overflow, zero
  );

  modport slave (
    input  ALUOP, port_a, port_b,
    output port_out, negative, overflow, zero
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter.
//   req   in  NREQ   request vector
//   ptr   in  PTR_W  index of the most recent winner (lowest priority)
//   grant out NREQ   one-hot grant; the first set request searching upward
//                    from ptr+1 and wrapping modulo NREQ, or zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic [PTR_W:0]  shamt;
  logic [NREQ-1:0] rot_req;
  logic [NREQ-1:0] rot_gnt;

  // Rotate the requests so that requester ptr+1 lands on bit 0, pick the
  // lowest set bit, then rotate the one-hot result back. Doubling the vector
  // turns each rotate into a plain shift, so any NREQ (not only powers of
  // two) wraps correctly.
  assign shamt   = {1'b0, ptr} + (PTR_W+1)'(1);
  assign rot_req = NREQ'({req, req} >> shamt);
  assign rot_gnt = rot_req & (~rot_req + NREQ'(1));
  assign grant   = NREQ'(({rot_gnt, rot_gnt} << shamt) >> NREQ);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NREQ requesters with round-robin arbitration and a
// req/gnt/rvalid handshake. The winner's operands are latched in the grant
// cycle, the ALU is driven only from those registers, and the ALU output is
// captured one cycle later and returned with an rvalid pulse.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   req      [NREQ]     level request, operands valid while high
//   aluop    [NREQ][4]  per-requester ALU operation (aluop_t encoding)
//   opa/opb  [NREQ][W]  per-requester operands
//   gnt      [NREQ]     one-hot: operands of that requester taken this cycle
//   rvalid   [NREQ]     one-hot: result/flags valid for that requester
//   result, negative, overflow, zero   registered ALU outputs (shared bus)
//   busy                high while an op is in EXEC or RESP
//   alu                 master side of alu_if
//
// Optional feature (macro ALU_ARBITER_PERF_EN):
//   grant_cnt [NREQ][16]  saturating per-requester grant counters
//   stall_cnt [16]        saturating count of cycles with a request pending
//                         and no grant
// -----------------------------------------------------------------------------
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0][3:0]         aluop,
  input  logic [NREQ-1:0][WORD_W-1:0]  opa,
  input  logic [NREQ-1:0][WORD_W-1:0]  opb,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              rvalid,
  output logic [WORD_W-1:0]            result,
  output logic                         negative,
  output logic                         overflow,
  output logic                         zero,
  output logic                         busy,
`ifdef ALU_ARBITER_PERF_EN
  output logic [NREQ-1:0][15:0]        grant_cnt,
  output logic [15:0]                  stall_cnt,
`endif
  alu_if.master                        alu
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  aluop_t            op_q, op_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [PTR_W-1:0]  arb_ptr;
  logic [NREQ-1:0]   arb_grant;
  logic [NREQ-1:0]   gnt_int;
  logic [NREQ-1:0]   gnt_shift;
  logic [PTR_W-1:0]  win_idx;
  logic              accept;

  // In RESP the finishing owner already counts as the most recent winner,
  // so a back-to-back grant sees the rotated priority in the same cycle.
  assign arb_ptr = (state_q == RESP) ? owner_q : ptr_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req   (req),
    .ptr   (arb_ptr),
    .grant (arb_grant)
  );

  // The ALU is occupied during EXEC, so no operands can be accepted then.
  assign gnt_int = (state_q == EXEC) ? '0 : arb_grant;
  assign accept  = |gnt_int;

  // One-hot to index.
  always_comb begin
    gnt_shift = '0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_shift = gnt_int >> i;
      if (gnt_shift[0]) win_idx = PTR_W'(i);
    end
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first, so paths that do not assign
    // it cannot infer a latch.
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE: ;
      EXEC: begin
        result_d = alu.port_out;
        neg_d    = alu.negative;
        ovf_d    = alu.overflow;
        zero_d   = alu.zero;
        state_d  = RESP;
      end
      RESP: begin
        ptr_d   = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A grant (only possible in IDLE or RESP) overrides the next state.
    if (accept) begin
      owner_d = win_idx;
      op_d    = aluop_t'(aluop[win_idx]);
      a_d     = opa[win_idx];
      b_d     = opb[win_idx];
      state_d = EXEC;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ptr_q    <= PTR_W'(NREQ - 1);
      owner_q  <= '0;
      op_q     <= ALU_SLL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  // NOTE: gnt is combinational from req, so it is also forced low while RST is
  // held; otherwise a requester could see its operands "accepted" by a block
  // that is in reset.
  assign gnt      = RST ? '0 : gnt_int;
  assign rvalid   = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign busy     = (state_q != IDLE);
  assign result   = result_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

  // ALU inputs come only from the latched registers and therefore hold
  // steady between grants.
  assign alu.ALUOP  = op_q;
  assign alu.port_a = a_q;
  assign alu.port_b = b_q;

`ifdef ALU_ARBITER_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  for (genvar g = 0; g < NREQ; g++) begin : g_grant_cnt
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (gnt_int[g] && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign grant_cnt[g] = cnt_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req) && !accept && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one alu instance (via alu_if) between NREQ requesters (cores/units) using round-robin arbitration and a req/gnt/rvalid handshake.
- Latches the winner's operands and op, drives the ALU from registers, registers port_out and flags, and returns them to the owner.
- Sits between the per-core execute stages and a single shared ALU.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WORD_W, 32, operand/result width; must match alu_if.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request; level, held with valid operands.
- aluop  in  NREQ x 4  per-requester ALUOP (aluop_t).
- opa  in  NREQ x WORD_W  per-requester port_a.
- opb  in  NREQ x WORD_W  per-requester port_b.
- gnt  out  NREQ  one-hot pulse; operands of that requester accepted this cycle.
- rvalid  out  NREQ  one-hot pulse; result/flags valid for that requester.
- result  out  WORD_W  registered ALU port_out, shared bus.
- negative, overflow, zero  out  1 each  registered ALU flags, shared bus.
- busy  out  1  high in EXEC or RESP.
- alu  modport  —  master side of alu_if: drives ALUOP, port_a, port_b; reads port_out and flags.

Behaviour:
- Reset (async, immediate on RST=1): state=IDLE; rr pointer=NREQ-1, so requester 0 has top priority; gnt=0, rvalid=0, result=0, flags=0, busy=0, operand registers=0.
- States:
  - IDLE: if |req, gnt[w]=1 combinationally, latch aluop[w]/opa[w]/opb[w] and owner=w at the edge, then go to EXEC. Otherwise stay.
  - EXEC: drive the ALU only from the latched registers; capture port_out and flags into the result registers at the edge; go to RESP.
  - RESP: rvalid[owner]=1; result and flags hold the captured values; rr pointer<=owner.
    - If |req in the same cycle, arbitrate with the updated priority (owner is now lowest), assert gnt, latch, and go to EXEC (back-to-back).
    - Otherwise go to IDLE.
- Round-robin: winner is the first requester with req set, searching from pointer+1 and wrapping modulo NREQ. Only one gnt bit is ever set.
- Latency: gnt in cycle N, rvalid in cycle N+2. Sustained throughput is one op per 2 cycles.
- Handshake:
  - Operands are sampled only in the gnt cycle.
  - A req still high in the cycle after gnt counts as a new request.
  - The requester must not expect a result before rvalid.
  - req dropped before gnt means the request is withdrawn, with no side effects.
- result and flags remain stable after rvalid until the next EXEC capture.
- Outside EXEC, the ALU inputs hold the last latched values; there is no toggling.
- Arithmetic, width and flag semantics are entirely those of the ALU; the arbiter performs no transformation.
- Reset mid-operation (EXEC or RESP): the in-flight op is dropped, no rvalid is issued, and the pointer resets.
- Simultaneous req from all requesters: strict rotation, no starvation; worst-case wait is NREQ grants.

Optional Feature:
- Macro ALU_ARBITER_PERF_EN.
- Defined:
  - Adds output grant_cnt (NREQ x 16): per-requester saturating grant counters (stop at 16'hFFFF) and a stall_cnt (16, saturating) counting cycles with req pending but not granted.
  - All counters clear on RST.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_types_pkg):
  - aluop_t (4-bit enum: ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU).
  - word_t (WORD_W bits).
  - Local arb_state_t {IDLE, EXEC, RESP}, defined in the package.
- Sub-module rr_arbiter: parameter NREQ; inputs req and pointer; output one-hot grant. It is purely combinational and reused by other shared resources.

Test Plan:
- Single ADD: req0 with ALU_ADD, opa=32'h0000_0005, opb=32'h0000_0003 -> gnt[0] cycle N; rvalid[0] cycle N+2; result=32'h8; zero=0.
- Contention: req0 and req1 both held with SUB 7-7 and ADD 1-1 -> grants alternate 0,1,0,1. Requester 0 gets result=0 with zero=1. Requester 1 gets result=2. Back-to-back spacing is 2 cycles.
- Overflow: req1 with ALU_ADD, 32'h7FFF_FFFF + 32'h1 -> result=32'h8000_0000, overflow=1, negative=1.
- Withdraw: req1 asserted for one cycle while requester 0 is in EXEC, dropped before RESP -> no gnt[1] and no rvalid[1].
- Reset mid-op: RST pulsed during EXEC -> no rvalid. All outputs are 0 in the same cycle. The next simultaneous req0/req1 grants requester 0 first.
- Perf (ALU_ARBITER_PERF_EN): 3 grants to requester 0 with 2 stall cycles -> grant_cnt[0]=3, stall_cnt=2; counters clear on RST.
